// File: rtl/instruction_loader_pkg.sv
// Shared constants for the instruction loader: FSM encodings,
// UART byte width and the default end-of-program marker.
package instruction_loader_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_RECV  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Big-endian byte packer: shifts UART bytes into a LEN-bit word and
// flags the byte that completes it.
module instruction_loader_byte_assembler
  import instruction_loader_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clr,
  input  logic           i_en,
  input  logic [7:0]     i_byte,
  output logic [LEN-1:0] o_word,
  output logic           o_word_ready
);

  localparam int NB = LEN / BYTE_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [LEN-1:0] shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last;

  assign last = (cnt_q == CW'(NB - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (i_clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (i_en) begin
      shift_d = (shift_q << BYTE_W) | LEN'(i_byte);
      cnt_d   = last ? '0 : cnt_q + 1'b1;
    end
  end

  // Word is presented in the same cycle as the completing byte
  assign o_word       = shift_d;
  assign o_word_ready = i_en && !i_clr && last;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// UART-to-instruction-RAM loader; stalls the pipeline until loaded.
// Optional trailing XOR checksum with LOADER_CHECKSUM_EN.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int             LEN       = 32,
  parameter int             RAM_DEPTH = 2048,
  parameter int             ADDR_W    = $clog2(RAM_DEPTH),
  parameter logic [LEN-1:0] HALT_WORD = LEN'(HALT_WORD_DEF)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  input  logic              i_reload,
  output logic              o_wea,
  output logic [ADDR_W-1:0] o_addra,
  output logic [LEN-1:0]    o_dina,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic              o_chk_err
`endif
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [LEN-1:0]    dina_q, dina_d;
  logic              ovf_q, ovf_d;
  logic [LEN-1:0]    word;
  logic              word_ready;
  logic              halt_w;
  logic              last_addr;
  logic              accept;
  logic              clr;

  assign halt_w    = (state_q == ST_WRITE) && (dina_q == HALT_WORD);
  assign last_addr = (addr_q == ADDR_W'(RAM_DEPTH - 1));
  // A byte during the HALT write belongs to the checksum, not a new word
  assign accept    = i_rx_done &&
                     ((state_q == ST_RECV) ||
                      ((state_q == ST_WRITE) && !halt_w));
  assign clr       = (state_q == ST_DONE) && i_reload;

  instruction_loader_byte_assembler #(.LEN(LEN)) u_asm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr        (clr),
    .i_en         (accept),
    .i_byte       (i_rx_data),
    .o_word       (word),
    .o_word_ready (word_ready)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    dina_d  = dina_q;
    ovf_d   = ovf_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d   = accept ? (xor_q ^ i_rx_data) : xor_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_RECV: begin
        if (word_ready) begin
          dina_d  = word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        count_d = count_q + 1'b1;
        if (!last_addr) addr_d = addr_q + 1'b1;
        if (halt_w) begin
`ifdef LOADER_CHECKSUM_EN
          if (i_rx_done) begin
            err_d   = (i_rx_data != xor_q);
            state_d = ST_DONE;
          end else begin
            state_d = ST_CHECK;
          end
`else
          state_d = ST_DONE;
`endif
        end else if (last_addr) begin
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else if (word_ready) begin
          dina_d  = word;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (i_rx_done) begin
          err_d   = (i_rx_data != xor_q);
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (i_reload) begin
          state_d = ST_RECV;
          addr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          xor_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_RECV;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_RECV;
      addr_q  <= '0;
      count_q <= '0;
      dina_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      dina_q  <= dina_d;
      ovf_q   <= ovf_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
      err_q   <= err_d;
`endif
    end
  end

  assign o_wea        = (state_q == ST_WRITE);
  assign o_addra      = addr_q;
  assign o_dina       = dina_q;
  assign o_busy       = (state_q != ST_DONE);
  assign o_done       = (state_q == ST_DONE);
  assign o_overflow   = ovf_q;
  assign o_word_count = count_q;
`ifdef LOADER_CHECKSUM_EN
  assign o_chk_err    = err_q;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Directed + randomized bench for instruction_loader (RAM_DEPTH=4).
// Set LOADER_CHECKSUM_EN to exercise the trailing checksum byte.
module tb_instruction_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_done = 1'b0;
  logic          reload = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          wea;
  logic [AW-1:0] addra;
  logic [31:0]   dina;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [AW:0]   wc;
`ifdef LOADER_CHECKSUM_EN
  logic          chk_err;
`endif

  instruction_loader #(.LEN(32), .RAM_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_reload     (reload),
    .o_wea        (wea),
    .o_addra      (addra),
    .o_dina       (dina),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (ovf),
    .o_word_count (wc)
`ifdef LOADER_CHECKSUM_EN
    ,
    .o_chk_err    (chk_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned a;
    logic [31:0] d;
  } wr_t;

  wr_t cap[$];
  wr_t exp_q[$];
  int total = 0;
  int bad = 0;
  logic [7:0] xr = 8'h00;

  always @(negedge clk)
    if (wea === 1'b1) cap.push_back('{int'(addra), dina});

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    xr = xr ^ b;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[31:24]);
      t = t << 8;
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    xr = 8'h00;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_n"}, 64'(cap.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      chk({tag, "_a"}, 64'(cap[i].a), 64'(exp_q[i].a));
      chk({tag, "_d"}, 64'(cap[i].d), 64'(exp_q[i].d));
    end
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom();
    if (w == HALT) w = 32'h0000_0013;
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w1;
    logic [31:0] ws[$];
    int n;
    bit corrupt;
    logic [7:0] tb_byte;

    // reset held for two cycles
    idle(2);
    rst = 1'b1;
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_wea", 64'(wea), 64'd0);
    chk("rst_addr", 64'(addra), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wc", 64'(wc), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_dina", 64'(dina), 64'd0);
`ifdef LOADER_CHECKSUM_EN
    chk("rst_err", 64'(chk_err), 64'd0);
`endif

    // first word: write one cycle after the last byte
    cap.delete();
    exp_q.delete();
    send_byte(8'h20);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h05);
    chk("w0_wea", 64'(wea), 64'd1);
    chk("w0_addr", 64'(addra), 64'd0);
    chk("w0_dina", 64'(dina), 64'h2001_0005);
    idle(1);
    chk("w0_wea_off", 64'(wea), 64'd0);
    chk("w0_addr_inc", 64'(addra), 64'd1);
    chk("w0_wc", 64'(wc), 64'd1);

    // second word then HALT (and checksum byte)
    w1 = rnd_word();
    send_word(w1, 1'b1);
    send_word(HALT, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(xr);
`endif
    wait_done("halt_done");
    exp_q.push_back('{0, 32'h2001_0005});
    exp_q.push_back('{1, w1});
    exp_q.push_back('{2, HALT});
    check_writes("halt_wr");
    chk("halt_busy", 64'(busy), 64'd0);
    chk("halt_wc", 64'(wc), 64'd3);
    chk("halt_ovf", 64'(ovf), 64'd0);
`ifdef LOADER_CHECKSUM_EN
    chk("halt_err", 64'(chk_err), 64'd0);
`endif

    // bytes in DONE are ignored
    send_word(32'h1234_5678, 1'b0);
    idle(2);
    chk("done_ign_n", 64'(cap.size()), 64'd3);
    chk("done_ign_wc", 64'(wc), 64'd3);

    // randomized reload rounds against a word-list model
    for (int r = 0; r < 8; r++) begin
      do_reload();
      chk("rl_busy", 64'(busy), 64'd1);
      chk("rl_wc", 64'(wc), 64'd0);
      cap.delete();
      exp_q.delete();
      ws.delete();
      n = (r == 0) ? 1 : (r == 1) ? 4 : $urandom_range(0, 5);
      corrupt = (r % 2) == 1;
      for (int i = 0; i < n; i++) ws.push_back(rnd_word());
      for (int i = 0; i < n; i++) send_word(ws[i], 1'b1);
      send_word(HALT, 1'b1);
      tb_byte = corrupt ? (xr ^ 8'h5A) : xr;
`ifdef LOADER_CHECKSUM_EN
      if (n < DEPTH) send_byte(tb_byte);
`endif
      wait_done("rl_done");
      for (int i = 0; i < n && i < DEPTH; i++)
        exp_q.push_back('{i, ws[i]});
      if (n < DEPTH) exp_q.push_back('{n, HALT});
      check_writes("rl_wr");
      chk("rl_wc_end", 64'(wc), (n < DEPTH) ? 64'(n + 1) : 64'(DEPTH));
      chk("rl_ovf", 64'(ovf), (n >= DEPTH) ? 64'd1 : 64'd0);
      chk("rl_busy_end", 64'(busy), 64'd0);
`ifdef LOADER_CHECKSUM_EN
      chk("rl_err", 64'(chk_err), (n < DEPTH && corrupt) ? 64'd1 : 64'd0);
`endif
      send_word(rnd_word(), 1'b0);
      idle(2);
      chk("rl_ign", 64'(cap.size()), 64'(exp_q.size()));
    end

    // reset mid-word discards the partial word
    do_reload();
    send_byte(8'h77);
    send_byte(8'h66);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    xr = 8'h00;
    cap.delete();
    exp_q.delete();
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    idle(2);
    exp_q.push_back('{0, 32'hAABB_CCDD});
    check_writes("rstmid");
    chk("rstmid_wc", 64'(wc), 64'd1);
    chk("rstmid_busy", 64'(busy), 64'd1);

    // reload outside DONE has no effect
    send_byte(8'h11);
    send_byte(8'h22);
    do_reload();
    xr = 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD ^ 8'h11 ^ 8'h22;
    send_byte(8'h33);
    send_byte(8'h44);
    idle(2);
    exp_q.push_back('{1, 32'h1122_3344});
    check_writes("rl_ign_busy");
    chk("rl_ign_wc", 64'(wc), 64'd2);

    // reset beats a simultaneous reload
    rst = 1'b0;
    reload = 1'b1;
    idle(1);
    rst = 1'b1;
    reload = 1'b0;
    chk("rst_win_wc", 64'(wc), 64'd0);
    chk("rst_win_addr", 64'(addra), 64'd0);
    chk("rst_win_busy", 64'(busy), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
